// File: rtl/hyperram_avmm_arbiter.sv
// Round-robin arbiter joining two Avalon-MM masters onto the single HyperRAM port.
// One transaction is in flight at a time; a read ends with real data or a timeout response.
module hyperram_avmm_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,
    input  logic              s_readdatavalid,
    input  logic              err_clear,
    output logic              err_timeout,
    output logic              err_stray,
    output logic              grant,
    output logic [1:0]        state_dbg_o
);

    // Valid/ready: a command transfers in a cycle where s_read|s_write is high
    // and s_waitrequest is low; mN_waitrequest mirrors that for the granted master.
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_TO_RESP = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_stray_q, err_stray_d;

    logic             req0, req1;
    logic             g_rd, g_wr;
    logic             rd_acc;
    logic             stray;
    logic             rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    assign g_rd   = grant_q ? m1_read  : m0_read;
    assign g_wr   = grant_q ? m1_write : m0_write;
    // Write takes priority when a master raises both commands at once.
    assign rd_acc = (state_q == ST_CMD) && g_rd && !g_wr && !s_waitrequest;
    assign stray  = s_readdatavalid && !(rd_acc || (state_q == ST_RD_WAIT));

    assign grant       = grant_q;
    assign err_timeout = err_timeout_q;
    assign err_stray   = err_stray_q;
    assign state_dbg_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b1;
            cnt_q         <= '0;
            err_timeout_q <= 1'b0;
            err_stray_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
            err_stray_q   <= err_stray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_CMD;
                    grant_d = (req0 && req1) ? ~grant_q : req1;
                end
            end
            ST_CMD: begin
                if (!g_rd && !g_wr) begin
                    state_d = ST_IDLE;
                end else if (!s_waitrequest) begin
                    if (g_wr || s_readdatavalid) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Data arriving on the final count still beats the timeout.
                if (s_readdatavalid) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_TO_RESP;
                end
            end
            ST_TO_RESP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        err_timeout_d = (err_timeout_q && !err_clear) || (state_q == ST_TO_RESP);
        err_stray_d   = (err_stray_q && !err_clear) || stray;
    end

    always_comb begin
        s_address        = grant_q ? m1_address   : m0_address;
        s_writedata      = grant_q ? m1_writedata : m0_writedata;
        s_read           = 1'b0;
        s_write          = 1'b0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        if (state_q == ST_CMD) begin
            s_write = g_wr;
            s_read  = g_rd && !g_wr;
            if (!s_waitrequest) begin
                m0_waitrequest = grant_q;
                m1_waitrequest = !grant_q;
            end
        end
        rsp_valid = (rd_acc && s_readdatavalid)
                  || ((state_q == ST_RD_WAIT) && s_readdatavalid)
                  || (state_q == ST_TO_RESP);
        rsp_data  = (state_q == ST_TO_RESP) ? ERR_DATA : s_readdata;
        m0_readdatavalid = rsp_valid && !grant_q;
        m1_readdatavalid = rsp_valid && grant_q;
        m0_readdata      = m0_readdatavalid ? rsp_data : '0;
        m1_readdata      = m1_readdatavalid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_hyperram_avmm_arbiter.sv
// Directed bench for hyperram_avmm_arbiter: expected commands and responses are queued
// by the stimulus and consumed by a negedge monitor.
module tb_hyperram_avmm_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic        s_readdatavalid;
    logic        err_clear;
    logic        err_timeout, err_stray;
    logic        grant;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // {write, address, writedata} and {port, readdata}
    logic [64:0] exp_cmd_q[$];
    logic [32:0] exp_rsp_q[$];

    // Downstream slave model: read data = {addr[15:0], 16'hC0DE} after slv_lat cycles.
    bit          slv_on = 1'b1;
    int          slv_lat = 3;
    int          slv_due_q[$];
    logic [31:0] slv_dat_q[$];
    logic        slv_rdv = 1'b0;
    logic [31:0] slv_data = '0;
    logic        man_rdv = 1'b0;
    logic [31:0] man_data = '0;

    assign s_readdatavalid = slv_rdv | man_rdv;
    assign s_readdata      = man_rdv ? man_data : slv_data;

    hyperram_avmm_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
        .err_clear(err_clear), .err_timeout(err_timeout), .err_stray(err_stray),
        .grant(grant), .state_dbg_o(state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk65(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave model
    always @(negedge clk) begin
        if (rst) begin
            slv_due_q.delete();
            slv_dat_q.delete();
        end else if (slv_on && s_read && !s_waitrequest) begin
            slv_due_q.push_back(cyc + slv_lat);
            slv_dat_q.push_back({s_address[15:0], 16'hC0DE});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            slv_rdv  = 1'b0;
            slv_data = '0;
            if (slv_due_q.size() > 0 && slv_due_q[0] == cyc) begin
                slv_rdv  = 1'b1;
                slv_data = slv_dat_q.pop_front();
                void'(slv_due_q.pop_front());
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if ((s_read || s_write) && !s_waitrequest) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected actual=%h expected=none",
                             {s_write, s_address, s_writedata});
                end else begin
                    chk65("cmd", {s_write, s_address, s_writedata}, exp_cmd_q.pop_front());
                end
            end
            if (m0_readdatavalid && m1_readdatavalid) begin
                checks++;
                errors++;
                $display("FAIL rsp_both_ports actual=11 expected=one");
            end else if (m0_readdatavalid || m1_readdatavalid) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=%b_%h expected=none", m1_readdatavalid,
                             m1_readdatavalid ? m1_readdata : m0_readdata);
                end else begin
                    chk65("rsp", {32'd0, m1_readdatavalid,
                                  m1_readdatavalid ? m1_readdata : m0_readdata},
                          {32'd0, exp_rsp_q.pop_front()});
                end
            end
        end
    end

    // Driver tasks
    task automatic set_cmd(input int p, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
        end
    endtask

    function automatic logic wait_of(input int p);
        return (p == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    // Called just after a posedge; returns just after the posedge following accept.
    task automatic m_issue(input int p, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input bit hold);
        int n;
        set_cmd(p, !wr, wr, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wait_of(p) && n < 64);
        if (wait_of(p)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout port=%0d actual=waiting expected=accepted", p);
        end
        @(posedge clk);
        #1;
        if (!hold) set_cmd(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp_q.size() != 0 || exp_cmd_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk32(name, 32'(exp_rsp_q.size() + exp_cmd_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        s_waitrequest = 1'b0;
        err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk1("rst_grant", grant, 1'b1);
        chk1("rst_idle", state_dbg == 2'd0, 1'b1);
        chk1("rst_s_read", s_read, 1'b0);
        chk1("rst_s_write", s_write, 1'b0);
        chk1("rst_m0_wait", m0_waitrequest, 1'b1);
        chk1("rst_m1_wait", m1_waitrequest, 1'b1);
        chk1("rst_m0_rdv", m0_readdatavalid, 1'b0);
        chk32("rst_m0_rdata", m0_readdata, 32'd0);
        chk1("rst_err_to", err_timeout, 1'b0);
        chk1("rst_err_stray", err_stray, 1'b0);

        // Single m0 write
        @(posedge clk);
        #1;
        exp_cmd_q.push_back({1'b1, 32'h10, 32'hA5A5_0001});
        set_cmd(0, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001);
        @(negedge clk);
        chk1("wr_idle_s_write", s_write, 1'b0);
        chk1("wr_idle_m0_wait", m0_waitrequest, 1'b1);
        @(negedge clk);
        chk1("wr_s_write", s_write, 1'b1);
        chk32("wr_s_address", s_address, 32'h10);
        chk32("wr_s_wdata", s_writedata, 32'hA5A5_0001);
        chk1("wr_m0_wait", m0_waitrequest, 1'b0);
        chk1("wr_m1_wait", m1_waitrequest, 1'b1);
        @(posedge clk);
        #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("wr_back_idle", state_dbg == 2'd0, 1'b1);
        chk1("wr_grant", grant, 1'b0);

        // Both masters reading continuously, latency 3: alternation from m0
        do_reset();
        slv_lat = 3;
        exp_cmd_q.push_back({1'b0, 32'h100, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0100_C0DE});
        exp_cmd_q.push_back({1'b0, 32'h200, 32'h0}); exp_rsp_q.push_back({1'b1, 32'h0200_C0DE});
        exp_cmd_q.push_back({1'b0, 32'h104, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0104_C0DE});
        exp_cmd_q.push_back({1'b0, 32'h204, 32'h0}); exp_rsp_q.push_back({1'b1, 32'h0204_C0DE});
        exp_cmd_q.push_back({1'b0, 32'h108, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0108_C0DE});
        exp_cmd_q.push_back({1'b0, 32'h208, 32'h0}); exp_rsp_q.push_back({1'b1, 32'h0208_C0DE});
        fork
            begin
                m_issue(0, 1'b0, 32'h100, 32'h0, 1'b1);
                m_issue(0, 1'b0, 32'h104, 32'h0, 1'b1);
                m_issue(0, 1'b0, 32'h108, 32'h0, 1'b0);
            end
            begin
                m_issue(1, 1'b0, 32'h200, 32'h0, 1'b1);
                m_issue(1, 1'b0, 32'h204, 32'h0, 1'b1);
                m_issue(1, 1'b0, 32'h208, 32'h0, 1'b0);
            end
        join
        drain("alt_drain");

        // m1 read stalled 5 cycles; m0 waits until m1's data returns
        do_reset();
        s_waitrequest = 1'b1;
        exp_cmd_q.push_back({1'b0, 32'h300, 32'h0}); exp_rsp_q.push_back({1'b1, 32'h0300_C0DE});
        exp_cmd_q.push_back({1'b0, 32'h400, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0400_C0DE});
        set_cmd(1, 1'b1, 1'b0, 32'h300, 32'h0);
        @(posedge clk);
        #1;
        set_cmd(0, 1'b1, 1'b0, 32'h400, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("stall_s_read", s_read, 1'b1);
            chk1("stall_m1_wait", m1_waitrequest, 1'b1);
            chk32("stall_addr", s_address, 32'h300);
            chk1("stall_grant", grant, 1'b1);
            @(posedge clk);
            #1;
        end
        s_waitrequest = 1'b0;
        @(negedge clk);
        chk1("stall_m1_accept", m1_waitrequest, 1'b0);
        @(posedge clk);
        #1;
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_m0_held", m0_waitrequest, 1'b1);
            chk1("stall_no_cmd", s_read, 1'b0);
        end
        n = 0;
        while (m0_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("stall_m0_granted", m0_waitrequest, 1'b0);
        @(posedge clk);
        #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        drain("stall_drain");

        // Command dropped before accept: back to IDLE, no command, grant kept
        s_waitrequest = 1'b1;
        set_cmd(1, 1'b1, 1'b0, 32'h320, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk1("drop_cmd_shown", s_read, 1'b1);
        @(posedge clk);
        #1;
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("drop_no_cmd", s_read, 1'b0);
        @(negedge clk);
        chk1("drop_idle", state_dbg == 2'd0, 1'b1);
        chk1("drop_no_cmd2", s_read, 1'b0);
        chk1("drop_grant", grant, 1'b1);
        @(posedge clk);
        #1;
        s_waitrequest = 1'b0;

        // Timeout: TIMEOUT_CYC=8, no data
        slv_on = 1'b0;
        exp_cmd_q.push_back({1'b0, 32'h500, 32'h0}); exp_rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
        set_cmd(0, 1'b1, 1'b0, 32'h500, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk1("to_accept", m0_waitrequest, 1'b0);
        @(posedge clk);
        #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m0_readdatavalid && n < 20);
        chk32("to_latency", 32'(n), 32'd8);
        chk1("to_m1_quiet", m1_readdatavalid, 1'b0);
        @(negedge clk);
        chk1("to_err_timeout", err_timeout, 1'b1);
        chk1("to_err_stray0", err_stray, 1'b0);
        @(posedge clk);
        #1;
        man_rdv = 1'b1;
        man_data = 32'h1234_5678;
        @(negedge clk);
        chk1("stray_m0_rdv", m0_readdatavalid, 1'b0);
        chk1("stray_m1_rdv", m1_readdatavalid, 1'b0);
        @(posedge clk);
        #1;
        man_rdv = 1'b0;
        @(negedge clk);
        chk1("stray_err", err_stray, 1'b1);
        @(posedge clk);
        #1;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        @(negedge clk);
        chk1("clr_err_timeout", err_timeout, 1'b0);
        chk1("clr_err_stray", err_stray, 1'b0);

        // Data on the last count before timeout wins
        @(posedge clk);
        #1;
        slv_on = 1'b1;
        slv_lat = 7;
        exp_cmd_q.push_back({1'b0, 32'h600, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0600_C0DE});
        m_issue(0, 1'b0, 32'h600, 32'h0, 1'b0);
        drain("lat7_drain");
        @(negedge clk);
        chk1("lat7_no_timeout", err_timeout, 1'b0);

        // Zero-latency read: data in the accept cycle
        @(posedge clk);
        #1;
        slv_on = 1'b0;
        exp_cmd_q.push_back({1'b0, 32'h650, 32'h0}); exp_rsp_q.push_back({1'b0, 32'hCAFE_0000});
        set_cmd(0, 1'b1, 1'b0, 32'h650, 32'h0);
        @(posedge clk);
        #1;
        man_rdv = 1'b1;
        man_data = 32'hCAFE_0000;
        @(negedge clk);
        chk1("zl_rdv", m0_readdatavalid, 1'b1);
        chk32("zl_rdata", m0_readdata, 32'hCAFE_0000);
        @(posedge clk);
        #1;
        man_rdv = 1'b0;
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("zl_idle", state_dbg == 2'd0, 1'b1);
        chk1("zl_no_stray", err_stray, 1'b0);
        chk1("zl_no_timeout", err_timeout, 1'b0);

        // Reset while in RD_WAIT
        @(posedge clk);
        #1;
        exp_cmd_q.push_back({1'b0, 32'h900, 32'h0});
        m_issue(0, 1'b0, 32'h900, 32'h0, 1'b0);
        @(negedge clk);
        chk1("rw_in_rd_wait", state_dbg == 2'd2, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk1("arst_idle", state_dbg == 2'd0, 1'b1);
        chk1("arst_grant", grant, 1'b1);
        chk1("arst_s_read", s_read, 1'b0);
        chk1("arst_m0_wait", m0_waitrequest, 1'b1);
        chk1("arst_m0_rdv", m0_readdatavalid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        slv_on = 1'b1;
        slv_lat = 2;
        exp_cmd_q.push_back({1'b0, 32'h700, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0700_C0DE});
        exp_cmd_q.push_back({1'b0, 32'h800, 32'h0}); exp_rsp_q.push_back({1'b1, 32'h0800_C0DE});
        fork
            m_issue(0, 1'b0, 32'h700, 32'h0, 1'b0);
            m_issue(1, 1'b0, 32'h800, 32'h0, 1'b0);
        join
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

endmodule
